alu_arb_ctrl: RTL

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

---
 rtl/alu_arb_ctrl_if.sv | 45 ++++
 rtl/alu_arb_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/alu_arb_ctrl_if.sv
// Requester, ALU and response signal bundle for the two-port ALU arbiter.
interface alu_arb_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             gate_en;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             sleep;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b, gate_en,
    output rsp_valid, rsp_id, rsp_result, sleep
  );

  // Requesters, ALU and consumer side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b, gate_en,
    input  rsp_valid, rsp_id, rsp_result, sleep
  );
endinterface

// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter issuing one operation at a time to a shared external
// ALU, with clock-gate enable, held response and idle-sleep indication.
module alu_arb_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  alu_arb_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(IDLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;
  logic [CNT_W-1:0] idle_cnt;
  logic             any_valid_c;
  logic             grant_c;
  logic             grant_id_c;

  // Arbitration: round-robin pointer breaks ties, a lone requester always wins
  always_comb begin
    any_valid_c = bus.req0_valid | bus.req1_valid;
    grant_id_c  = (bus.req0_valid && bus.req1_valid) ? ptr : bus.req1_valid;
    grant_c     = !rst && (state == S_IDLE) && any_valid_c;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (any_valid_c) state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_RESP;
      S_RESP: if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; everything forced low while reset is asserted
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.gate_en    = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.sleep      = 1'b0;
    if (!rst) begin
      bus.req0_ready = grant_c && !grant_id_c;
      bus.req1_ready = grant_c &&  grant_id_c;
      bus.gate_en    = (state == S_EXEC);
      bus.rsp_valid  = (state == S_RESP);
      bus.sleep      = (state == S_IDLE) && !any_valid_c && (idle_cnt >= CNT_THR);
    end
  end

  // Operand launch, result capture, pointer and idle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= 1'b0;
      idle_cnt       <= '0;
      bus.alu_op     <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= '0;
    end else begin
      if (grant_c) begin
        bus.alu_op <= grant_id_c ? bus.req1_op : bus.req0_op;
        bus.alu_a  <= grant_id_c ? bus.req1_a  : bus.req0_a;
        bus.alu_b  <= grant_id_c ? bus.req1_b  : bus.req0_b;
        bus.rsp_id <= grant_id_c;
        ptr        <= !grant_id_c;
      end
      if (state == S_EXEC) begin
        bus.rsp_result <= bus.alu_result;
      end
      if (state == S_IDLE && !any_valid_c) begin
        if (idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + CNT_W'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule
